// File: rtl/rrf_multiport.sv
// Rename register file: ring allocator, valid bits, data array.
// Ports: rd/com read, wr writeback, dp allocate, com release, flush.
module rrf_multiport #(
  parameter  int ENTRY_NUM = 64,
  parameter  int DATA_LEN  = 32,
  parameter  int WR_PORTS  = 5,
  parameter  int RD_PORTS  = 4,
  parameter  int DP_PORTS  = 2,
  parameter  int COM_PORTS = 2,
  localparam int SEL = $clog2(ENTRY_NUM),
  localparam int CNT = $clog2(DP_PORTS+1),
  localparam int CCW = $clog2(COM_PORTS+1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [RD_PORTS*SEL-1:0]       rd_tag,
  output logic [RD_PORTS-1:0]           rd_valid,
  output logic [RD_PORTS*DATA_LEN-1:0]  rd_data,
  input  logic [COM_PORTS*SEL-1:0]      com_tag,
  output logic [COM_PORTS*DATA_LEN-1:0] com_data,
  input  logic [WR_PORTS-1:0]           wr_en,
  input  logic [WR_PORTS*SEL-1:0]       wr_addr,
  input  logic [WR_PORTS*DATA_LEN-1:0]  wr_data,
  input  logic [CNT-1:0]                dp_num,
  output logic [DP_PORTS*SEL-1:0]       dp_tag,
  output logic                          dp_stall,
  input  logic [CCW-1:0]                com_num,
  input  logic                          flush,
  output logic [SEL:0]                  free_cnt
);

  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic [DATA_LEN-1:0]  data_q [ENTRY_NUM];
  logic [DATA_LEN-1:0]  data_d [ENTRY_NUM];
  logic [SEL-1:0]       alloc_ptr_q, alloc_ptr_d;
  logic [SEL-1:0]       com_ptr_q, com_ptr_d;
  logic [SEL:0]         used_q, used_d;
  logic                 grant;

  assign free_cnt = (SEL+1)'(ENTRY_NUM) - used_q;
  assign dp_stall = 32'(dp_num) > 32'(free_cnt);
  assign grant    = !dp_stall && !flush;

  always_comb begin
    dp_tag = '0;
    for (int i = 0; i < DP_PORTS; i++)
      dp_tag[i*SEL +: SEL] = alloc_ptr_q + SEL'(i);
  end

  always_comb begin
    com_ptr_d   = com_ptr_q + SEL'(com_num);
    alloc_ptr_d = alloc_ptr_q;
    used_d      = used_q - (SEL+1)'(com_num);
    if (flush) begin
      alloc_ptr_d = com_ptr_d;
      used_d      = '0;
    end else if (grant) begin
      alloc_ptr_d = alloc_ptr_q + SEL'(dp_num);
      used_d      = used_d + (SEL+1)'(dp_num);
    end
  end

  // Writebacks set valid first so a same-cycle allocation clear wins.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en[w]) begin
        valid_d[wr_addr[w*SEL +: SEL]] = 1'b1;
        if (!reset)
          data_d[wr_addr[w*SEL +: SEL]] = wr_data[w*DATA_LEN +: DATA_LEN];
      end
    end
    for (int i = 0; i < DP_PORTS; i++)
      if (grant && i < int'(dp_num))
        valid_d[alloc_ptr_q + SEL'(i)] = 1'b0;
    if (flush)
      valid_d = '0;
  end

  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    for (int r = 0; r < RD_PORTS; r++) begin
      rd_valid[r] = valid_q[rd_tag[r*SEL +: SEL]];
      rd_data[r*DATA_LEN +: DATA_LEN] = data_q[rd_tag[r*SEL +: SEL]];
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_en[w] && wr_addr[w*SEL +: SEL] == rd_tag[r*SEL +: SEL]) begin
          rd_valid[r] = 1'b1;
          rd_data[r*DATA_LEN +: DATA_LEN] = wr_data[w*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

  always_comb begin
    com_data = '0;
    for (int c = 0; c < COM_PORTS; c++)
      com_data[c*DATA_LEN +: DATA_LEN] = data_q[com_tag[c*SEL +: SEL]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      alloc_ptr_q <= '0;
      com_ptr_q   <= '0;
      used_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      alloc_ptr_q <= alloc_ptr_d;
      com_ptr_q   <= com_ptr_d;
      used_q      <= used_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: tb/tb_rrf_multiport.sv
// Directed bench for rrf_multiport with default parameters.
// Expected values are queued at stimulus time and popped at check time.
module tb_rrf_multiport;

  logic          clk = 1'b0;
  logic          reset;
  logic [23:0]   rd_tag;
  logic [3:0]    rd_valid;
  logic [127:0]  rd_data;
  logic [11:0]   com_tag;
  logic [63:0]   com_data;
  logic [4:0]    wr_en;
  logic [29:0]   wr_addr;
  logic [159:0]  wr_data;
  logic [1:0]    dp_num;
  logic [11:0]   dp_tag;
  logic          dp_stall;
  logic [1:0]    com_num;
  logic          flush;
  logic [6:0]    free_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sb_q [$];

  rrf_multiport dut (
    .clk(clk), .reset(reset),
    .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_data(rd_data),
    .com_tag(com_tag), .com_data(com_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dp_num(dp_num), .dp_tag(dp_tag), .dp_stall(dp_stall),
    .com_num(com_num), .flush(flush), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset)
      assert (int'(com_num) <= 64 - int'(free_cnt))
      else $error("FAIL com_num_legal: com_num %0d used %0d",
                  com_num, 64 - int'(free_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input logic [63:0] v);
    sb_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL %s: got %0h, scoreboard empty", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e)
      else begin
        n_bad++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input int p, input logic [5:0] a,
                    input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*6 +: 6] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic idle();
    wr_en = '0; dp_num = '0; com_num = '0; flush = 1'b0;
  endtask

  task automatic alloc_n(input int cycles, input logic [1:0] n);
    dp_num = n;
    for (int k = 0; k < cycles; k++) tick();
    dp_num = '0;
  endtask

  initial begin
    reset = 1'b1; rd_tag = '0; com_tag = '0;
    wr_addr = '0; wr_data = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    rd_tag = {6'd3, 6'd2, 6'd1, 6'd0};
    settle();
    push(64); chk("reset_free", 64'(free_cnt));
    push(0);  chk("reset_valid", 64'(rd_valid));
    push(0);  chk("reset_stall", 64'(dp_stall));

    dp_num = 2; settle();
    push({6'd1, 6'd0}); chk("alloc0_tag", 64'(dp_tag));
    tick(); settle();
    push(62); chk("alloc1_free", 64'(free_cnt));
    push({6'd3, 6'd2}); chk("alloc1_tag", 64'(dp_tag));
    tick(); settle();
    push({6'd5, 6'd4}); chk("alloc2_tag", 64'(dp_tag));
    tick(); dp_num = 0; settle();
    push(58); chk("alloc3_free", 64'(free_cnt));

    rd_tag = {6'd0, 6'd0, 6'd7, 6'd5};
    wr(0, 5, 32'hDEADBEEF);
    wr(1, 7, 32'h11111111);
    wr(3, 7, 32'h33333333);
    settle();
    push(1); chk("byp_valid", 64'(rd_valid[0]));
    push(32'hDEADBEEF); chk("byp_data", 64'(rd_data[31:0]));
    push(32'h33333333); chk("byp_hi_port", 64'(rd_data[63:32]));
    tick(); idle(); settle();
    push(1); chk("wr_valid", 64'(rd_valid[0]));
    push(32'hDEADBEEF); chk("wr_data", 64'(rd_data[31:0]));
    push(1); chk("dual_valid", 64'(rd_valid[1]));
    push(32'h33333333); chk("dual_hi_port", 64'(rd_data[63:32]));

    com_tag = {6'd0, 6'd5};
    wr(0, 5, 32'h12345678);
    wr(1, 20, 32'hCAFEF00D);
    settle();
    push(32'hDEADBEEF); chk("com_nobyp", 64'(com_data[31:0]));
    push(32'h12345678); chk("rd_byp2", 64'(rd_data[31:0]));
    tick(); idle(); settle();
    push(32'h12345678); chk("com_after", 64'(com_data[31:0]));

    alloc_n(28, 2);
    alloc_n(1, 1);
    settle();
    push(1); chk("near_full_free", 64'(free_cnt));
    dp_num = 2;
    wr(0, 63, 32'hA5A5A5A5);
    settle();
    push(1); chk("stall_on", 64'(dp_stall));
    push({6'd0, 6'd63}); chk("stall_tag", 64'(dp_tag));
    tick(); wr_en = '0;
    rd_tag = {6'd0, 6'd0, 6'd0, 6'd63};
    com_num = 2; settle();
    push(1); chk("stall_free", 64'(free_cnt));
    push(1); chk("stall_noclr", 64'(rd_valid[0]));
    push(1); chk("stall_no_credit", 64'(dp_stall));
    tick(); com_num = 0;
    rd_tag = {6'd0, 6'd0, 6'd0, 6'd63};
    wr(0, 0, 32'h0BADF00D);
    com_tag = {6'd0, 6'd0};
    settle();
    push(3); chk("commit_free", 64'(free_cnt));
    push(0); chk("commit_stall", 64'(dp_stall));
    push({6'd0, 6'd63}); chk("wrap_tag", 64'(dp_tag));
    push(1); chk("wrap_byp", 64'(rd_valid[1]));
    tick(); idle(); settle();
    push(0); chk("clr63", 64'(rd_valid[0]));
    push(0); chk("clr_wins", 64'(rd_valid[1]));
    push(32'h0BADF00D); chk("clr_data", 64'(com_data[31:0]));
    push(1); chk("post_wrap_free", 64'(free_cnt));
    push(1); chk("post_wrap_tag", 64'(dp_tag[5:0]));

    alloc_n(1, 1);
    settle();
    push(0); chk("full_free", 64'(free_cnt));
    dp_num = 1; settle();
    push(1); chk("full_stall1", 64'(dp_stall));
    dp_num = 0; settle();
    push(0); chk("full_stall0", 64'(dp_stall));

    flush = 1'b1; tick(); idle(); settle();
    push(64); chk("flush0_free", 64'(free_cnt));
    push(2); chk("flush0_tag", 64'(dp_tag[5:0]));
    alloc_n(5, 2);
    wr(0, 4, 32'h44444444);
    tick(); idle();
    rd_tag = {6'd0, 6'd0, 6'd6, 6'd4};
    settle();
    push(1); chk("pre_flush_valid", 64'(rd_valid[0]));
    push(54); chk("pre_flush_free", 64'(free_cnt));
    flush = 1'b1; com_num = 1; dp_num = 2;
    wr(0, 6, 32'h66666666);
    com_tag = {6'd0, 6'd6};
    tick(); idle(); settle();
    push({6'd4, 6'd3}); chk("flush_tag", 64'(dp_tag));
    push(64); chk("flush_free", 64'(free_cnt));
    push(0); chk("flush_valid", 64'(rd_valid));
    push(32'h66666666); chk("flush_data", 64'(com_data[31:0]));

    alloc_n(20, 2);
    wr(0, 10, 32'h10101010);
    tick(); idle();
    rd_tag = {6'd0, 6'd0, 6'd20, 6'd10};
    com_tag = {6'd0, 6'd20};
    settle();
    push(1); chk("pre_rst_valid", 64'(rd_valid[0]));
    push(24); chk("pre_rst_free", 64'(free_cnt));
    reset = 1'b1; flush = 1'b1; dp_num = 2; com_num = 1;
    wr(0, 20, 32'hBAD0BAD0);
    tick(); reset = 1'b0; idle(); settle();
    push(64); chk("rst_free", 64'(free_cnt));
    push({6'd1, 6'd0}); chk("rst_tag", 64'(dp_tag));
    push(0); chk("rst_valid", 64'(rd_valid));
    push(32'hCAFEF00D); chk("rst_nowrite", 64'(com_data[31:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
